ir_pointer_unit: RTL and testbench
==================================

Name: ir_pointer_unit

Overview:
- Instruction-pointer and fetch stage directly downstream of the core controller.
- Consumes the controller's 2-bit IR mode (IDLE/RST/WORK) and decoded jump/wait/stop commands.
- Owns the instruction pointer and drives fetch requests to instruction memory.
- Presents each fetched instruction word to the decoder with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, width of the pointer, the fetched word and the jump target.
- RESET_ADDR, 0, pointer value loaded while in reset or in RST mode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_ir_mode  in  2  controller mode: 2'b00 IDLE, 2'b01 RST, 2'b10 WORK, 2'b11 treated as IDLE
- i_jump_valid  in  1  jump/control command present this cycle
- i_jump_cmd  in  3  0 NONE, 1 LARGER, 2 SMALLER, 3 EQUAL, 4 UNEQUAL, 5 DIRECT, 6 WAIT, 7 STOP
- i_jump_target  in  DATA_WIDTH  branch destination
- i_flags  in  3  comparator flags {larger, smaller, equal}
- i_resume  in  1  leave the WAIT state
- o_fetch_req  out  1  instruction memory read request
- o_fetch_addr  out  DATA_WIDTH  read address, equals the pointer
- i_fetch_ack  in  1  memory data valid this cycle
- i_fetch_data  in  DATA_WIDTH  fetched word
- o_ir_valid  out  1  instruction word held for the decoder
- o_ir_data  out  DATA_WIDTH  instruction word
- i_ir_ready  in  1  decoder accepts the word
- o_pointer  out  DATA_WIDTH  current pointer
- o_stopped  out  1  core halted

Behaviour:
- Reset: rst high puts the FSM in S_RST. Reset values:
  - pointer = RESET_ADDR
  - o_fetch_req = 0, o_ir_valid = 0, o_ir_data = 0, o_stopped = 0
- All outputs are registered.
- States and transitions:
  - S_RST: leaves to S_FETCH on the first cycle with i_ir_mode == WORK.
  - S_FETCH: o_fetch_req = 1, o_fetch_addr = pointer. When i_fetch_ack is sampled high:
    - o_ir_data <= i_fetch_data, o_ir_valid <= 1
    - pointer <= pointer + 1, modulo 2^DATA_WIDTH (all-ones wraps to 0)
    - next state S_HOLD
  - S_HOLD: o_ir_valid stays high until i_ir_ready. On i_ir_ready: o_ir_valid <= 0, next state S_FETCH (or the jump outcome below).
  - S_WAIT: o_fetch_req = 0, o_ir_valid = 0. i_resume moves to S_FETCH with the pointer unchanged.
  - S_STOP: o_stopped = 1, no fetches. Left only via rst or RST mode.
- Jump commands:
  - Evaluated only in S_HOLD; i_jump_valid in any other state is ignored (checked by assertion).
  - Taken conditions:
    - LARGER: flags[2]
    - SMALLER: flags[1]
    - EQUAL: flags[0]
    - UNEQUAL: !flags[0]
    - DIRECT: always
  - A taken jump sets pointer <= i_jump_target; a not-taken jump leaves the pointer unchanged.
  - WAIT: next state S_WAIT, entered once i_ir_ready is high.
  - STOP: next state S_STOP, entered once i_ir_ready is high.
  - NONE: no effect.
  - Jump and ready in the same cycle: the jump is applied and the next fetch uses the new pointer.
  - Jump before ready: the pointer is updated immediately and the state stays S_HOLD. Multiple jumps in S_HOLD: the last one wins.
- Latency:
  - Ack in cycle N gives o_ir_valid high in cycle N+1.
  - Ready in cycle M gives o_fetch_req high in cycle M+1.
  - Minimum 2 cycles per instruction.
- Mode RST at any time (mid-fetch included): next cycle S_RST with reset values. An outstanding request is abandoned and a late ack is ignored.
- Mode IDLE:
  - The FSM and pointer freeze.
  - o_fetch_req is forced to 0 and i_fetch_ack is ignored.
  - o_ir_valid/o_ir_data keep their values; ready is ignored.
  - WORK resumes from the frozen state.
- rst takes priority over the mode; mode RST takes priority over all jump and handshake events.

Optional Feature:
- IR_JUMP_STATS_EN defined:
  - Adds o_jump_taken_cnt (16 bit), incremented on every taken jump.
  - The counter saturates at 16'hFFFF and is cleared by rst or RST mode.
- IR_JUMP_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/define file holds:
  - the IR mode encodings (IDLE/RST/WORK, shared with the controller)
  - the jump command encodings
  - the FSM state encodings
  - the flag bit positions
- One natural sub-module: jump_resolver. It is combinational and maps cmd, flags and valid to take, wait_req and stop_req.

Test Plan:
- rst, then mode WORK, memory acks with a 1-cycle delay returning 16'h1234 → o_fetch_addr 0, o_ir_data 16'h1234, o_pointer 1, o_ir_valid held until ready.
- In S_HOLD, i_jump_cmd EQUAL with flags 3'b001 and target 16'h0040, ready in the same cycle → next o_fetch_addr 16'h0040. Repeat with flags 3'b100 → sequential address.
- Pointer at 16'hFFFF, ack → o_pointer wraps to 0 and the next fetch address is 0.
- WAIT command with ready → no requests for 5 cycles; i_resume → fetch at the unchanged pointer.
- STOP command → o_stopped 1 and no requests. Mode RST then WORK → o_stopped 0 and fetch at RESET_ADDR.
- Mode RST asserted while o_fetch_req is high, ack arriving one cycle later → ack ignored, o_ir_valid stays 0, pointer = RESET_ADDR.

Source files
------------

// File: rtl/ir_pointer_unit_pkg.sv
// -----------------------------------------------------------------------------
// ir_pointer_unit_pkg
// Shared encodings for the instruction-pointer / fetch stage:
//   - IR mode encodings driven by the core controller (IDLE/RST/WORK)
//   - jump/control command encodings produced by the decoder
//   - FSM state encodings of ir_pointer_unit
//   - bit positions inside the comparator flag vector {larger, smaller, equal}
// -----------------------------------------------------------------------------
package ir_pointer_unit_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'b00,
      MODE_RST  = 2'b01,
      MODE_WORK = 2'b10,
      MODE_RSVD = 2'b11   // behaves exactly like IDLE
   } ir_mode_e;

   typedef enum logic [2:0] {
      CMD_NONE    = 3'd0,
      CMD_LARGER  = 3'd1,
      CMD_SMALLER = 3'd2,
      CMD_EQUAL   = 3'd3,
      CMD_UNEQUAL = 3'd4,
      CMD_DIRECT  = 3'd5,
      CMD_WAIT    = 3'd6,
      CMD_STOP    = 3'd7
   } jump_cmd_e;

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_FETCH = 3'd1,
      S_HOLD  = 3'd2,
      S_WAIT  = 3'd3,
      S_STOP  = 3'd4
   } state_e;

   localparam int FLAG_LARGER  = 2;
   localparam int FLAG_SMALLER = 1;
   localparam int FLAG_EQUAL   = 0;

   localparam int JUMP_CNT_WIDTH = 16;

endpackage

// File: rtl/ir_pointer_unit_jump_resolver.sv
// -----------------------------------------------------------------------------
// ir_pointer_unit_jump_resolver
// Purely combinational decode of a jump/control command against the
// comparator flags.
// Ports:
//   i_valid     command present (already qualified by the caller)
//   i_cmd       jump command encoding (jump_cmd_e)
//   i_flags     comparator flags {larger, smaller, equal}
//   o_take      branch is taken: load the jump target into the pointer
//   o_wait_req  WAIT command: park in S_WAIT after the current word
//   o_stop_req  STOP command: halt in S_STOP after the current word
// -----------------------------------------------------------------------------
module ir_pointer_unit_jump_resolver
   import ir_pointer_unit_pkg::*;
(
   input  logic       i_valid,
   input  logic [2:0] i_cmd,
   input  logic [2:0] i_flags,
   output logic       o_take,
   output logic       o_wait_req,
   output logic       o_stop_req
);

   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no path can leave it unassigned and infer a latch.
      o_take     = 1'b0;
      o_wait_req = 1'b0;
      o_stop_req = 1'b0;
      if (i_valid) begin
         case (jump_cmd_e'(i_cmd))
            CMD_NONE:    ;
            CMD_LARGER:  o_take     = i_flags[FLAG_LARGER];
            CMD_SMALLER: o_take     = i_flags[FLAG_SMALLER];
            CMD_EQUAL:   o_take     = i_flags[FLAG_EQUAL];
            CMD_UNEQUAL: o_take     = !i_flags[FLAG_EQUAL];
            CMD_DIRECT:  o_take     = 1'b1;
            CMD_WAIT:    o_wait_req = 1'b1;
            CMD_STOP:    o_stop_req = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ir_pointer_unit.sv
// -----------------------------------------------------------------------------
// ir_pointer_unit
// Instruction pointer and fetch stage behind the core controller. Owns the
// instruction pointer, issues fetch requests to instruction memory, holds
// each fetched word for the decoder under a valid/ready handshake and applies
// jump / WAIT / STOP commands while a word is held.
//
// Configuration macro: IR_JUMP_STATS_EN adds o_jump_taken_cnt, a saturating
// count of taken jumps cleared by rst or RST mode.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_ir_mode         controller mode (IDLE/RST/WORK, 2'b11 = IDLE)
//   i_jump_valid      jump/control command present
//   i_jump_cmd        command encoding (jump_cmd_e)
//   i_jump_target     branch destination
//   i_flags           comparator flags {larger, smaller, equal}
//   i_resume          leave S_WAIT
//   o_fetch_req       instruction memory read request
//   o_fetch_addr      read address (the pointer)
//   i_fetch_ack       memory data valid
//   i_fetch_data      fetched word
//   o_ir_valid        instruction word held for the decoder
//   o_ir_data         instruction word
//   i_ir_ready        decoder accepts the word
//   o_pointer         current pointer
//   o_stopped         core halted
//   o_jump_taken_cnt  taken-jump counter (IR_JUMP_STATS_EN only)
// -----------------------------------------------------------------------------
module ir_pointer_unit
   import ir_pointer_unit_pkg::*;
#(
   parameter int unsigned               DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0]     RESET_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            i_ir_mode,
   input  logic                  i_jump_valid,
   input  logic [2:0]            i_jump_cmd,
   input  logic [DATA_WIDTH-1:0] i_jump_target,
   input  logic [2:0]            i_flags,
   input  logic                  i_resume,
   output logic                  o_fetch_req,
   output logic [DATA_WIDTH-1:0] o_fetch_addr,
   input  logic                  i_fetch_ack,
   input  logic [DATA_WIDTH-1:0] i_fetch_data,
   output logic                  o_ir_valid,
   output logic [DATA_WIDTH-1:0] o_ir_data,
   input  logic                  i_ir_ready,
   output logic [DATA_WIDTH-1:0] o_pointer,
   output logic                  o_stopped
`ifdef IR_JUMP_STATS_EN
   ,
   output logic [JUMP_CNT_WIDTH-1:0] o_jump_taken_cnt
`endif
);

   state_e                r_state;
   logic [DATA_WIDTH-1:0] r_pointer;
   logic                  r_fetch_req;
   logic                  r_ir_valid;
   logic [DATA_WIDTH-1:0] r_ir_data;
   logic                  r_stopped;
   // WAIT/STOP seen in S_HOLD before the decoder released the word.
   logic                  r_pend_wait;
   logic                  r_pend_stop;

   state_e                w_next_state;
   logic [DATA_WIDTH-1:0] w_next_pointer;
   logic                  w_next_fetch_req;
   logic                  w_next_ir_valid;
   logic [DATA_WIDTH-1:0] w_next_ir_data;
   logic                  w_next_stopped;
   logic                  w_next_pend_wait;
   logic                  w_next_pend_stop;

   logic                  w_mode_work;
   logic                  w_cmd_valid;
   logic                  w_take;
   logic                  w_wait_req;
   logic                  w_stop_req;

   assign w_mode_work = (ir_mode_e'(i_ir_mode) == MODE_WORK);
   // Commands only count while a word is held and the core is running.
   assign w_cmd_valid = i_jump_valid && (r_state == S_HOLD) && w_mode_work;

   ir_pointer_unit_jump_resolver u_jump_resolver (
      .i_valid    (w_cmd_valid),
      .i_cmd      (i_jump_cmd),
      .i_flags    (i_flags),
      .o_take     (w_take),
      .o_wait_req (w_wait_req),
      .o_stop_req (w_stop_req)
   );

   always_comb begin
      w_next_state     = r_state;
      w_next_pointer   = r_pointer;
      w_next_fetch_req = 1'b0;
      w_next_ir_valid  = r_ir_valid;
      w_next_ir_data   = r_ir_data;
      w_next_stopped   = r_stopped;
      w_next_pend_wait = r_pend_wait;
      w_next_pend_stop = r_pend_stop;

      case (ir_mode_e'(i_ir_mode))
         MODE_RST: begin
            // Abandons any outstanding request; a late ack lands in S_RST
            // and is dropped.
            w_next_state     = S_RST;
            w_next_pointer   = RESET_ADDR;
            w_next_ir_valid  = 1'b0;
            w_next_ir_data   = '0;
            w_next_stopped   = 1'b0;
            w_next_pend_wait = 1'b0;
            w_next_pend_stop = 1'b0;
         end
         MODE_WORK: begin
            case (r_state)
               S_RST: w_next_state = S_FETCH;
               S_FETCH: begin
                  // Qualified with the request so an ack in the first cycle
                  // after an IDLE freeze is not taken for ours.
                  if (i_fetch_ack && r_fetch_req) begin
                     w_next_ir_data  = i_fetch_data;
                     w_next_ir_valid = 1'b1;
                     w_next_pointer  = r_pointer + DATA_WIDTH'(1);
                     w_next_state    = S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (w_take) begin
                     w_next_pointer = i_jump_target;
                  end
                  // Any real command replaces an earlier pending WAIT/STOP.
                  if (w_cmd_valid && (jump_cmd_e'(i_jump_cmd) != CMD_NONE)) begin
                     w_next_pend_wait = w_wait_req;
                     w_next_pend_stop = w_stop_req;
                  end
                  if (i_ir_ready) begin
                     w_next_ir_valid = 1'b0;
                     if (w_next_pend_stop) begin
                        w_next_state = S_STOP;
                     end else if (w_next_pend_wait) begin
                        w_next_state = S_WAIT;
                     end else begin
                        w_next_state = S_FETCH;
                     end
                     w_next_pend_wait = 1'b0;
                     w_next_pend_stop = 1'b0;
                  end
               end
               S_WAIT: begin
                  if (i_resume) begin
                     w_next_state = S_FETCH;
                  end
               end
               S_STOP: ;
               default: w_next_state = S_RST;
            endcase
            // Registered outputs are derived from the state being entered.
            w_next_fetch_req = (w_next_state == S_FETCH);
            w_next_stopped   = (w_next_state == S_STOP);
         end
         default: ;  // IDLE: freeze everything, drop the request
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
      if (rst) begin
         r_state     <= S_RST;
         r_pointer   <= RESET_ADDR;
         r_fetch_req <= 1'b0;
         r_ir_valid  <= 1'b0;
         r_ir_data   <= '0;
         r_stopped   <= 1'b0;
         r_pend_wait <= 1'b0;
         r_pend_stop <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_pointer   <= w_next_pointer;
         r_fetch_req <= w_next_fetch_req;
         r_ir_valid  <= w_next_ir_valid;
         r_ir_data   <= w_next_ir_data;
         r_stopped   <= w_next_stopped;
         r_pend_wait <= w_next_pend_wait;
         r_pend_stop <= w_next_pend_stop;
      end
   end

`ifdef IR_JUMP_STATS_EN
   logic [JUMP_CNT_WIDTH-1:0] r_jump_cnt;

   always_ff @(posedge clk) begin
      if (rst || (ir_mode_e'(i_ir_mode) == MODE_RST)) begin
         r_jump_cnt <= '0;
      end else if (w_take && (r_jump_cnt != {JUMP_CNT_WIDTH{1'b1}})) begin
         r_jump_cnt <= r_jump_cnt + JUMP_CNT_WIDTH'(1);
      end
   end

   assign o_jump_taken_cnt = r_jump_cnt;
`endif

   assign o_fetch_req  = r_fetch_req;
   assign o_fetch_addr = r_pointer;
   assign o_pointer    = r_pointer;
   assign o_ir_valid   = r_ir_valid;
   assign o_ir_data    = r_ir_data;
   assign o_stopped    = r_stopped;

`ifndef SYNTHESIS
   // A jump command outside S_HOLD must never move the pointer: outside
   // S_HOLD only an accepted fetch or RST mode may change it.
   a_jump_ignored_outside_hold : assert property (
      @(posedge clk) disable iff (rst)
      ((r_state != S_HOLD) && (ir_mode_e'(i_ir_mode) != MODE_RST) &&
       !((r_state == S_FETCH) && i_fetch_ack && r_fetch_req))
      |=> $stable(r_pointer)
   );
`endif

endmodule

// File: tb/tb_ir_pointer_unit.sv
// -----------------------------------------------------------------------------
// tb_ir_pointer_unit
// Directed bench for ir_pointer_unit: a table of jump vectors applied in a
// loop, plus hand-written sequences for reset, wrap, WAIT, STOP, RST mode
// mid-fetch and IDLE freeze.
// -----------------------------------------------------------------------------
module tb_ir_pointer_unit;
   import ir_pointer_unit_pkg::*;

   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic [1:0]    i_ir_mode;
   logic          i_jump_valid;
   logic [2:0]    i_jump_cmd;
   logic [DW-1:0] i_jump_target;
   logic [2:0]    i_flags;
   logic          i_resume;
   logic          o_fetch_req;
   logic [DW-1:0] o_fetch_addr;
   logic          i_fetch_ack;
   logic [DW-1:0] i_fetch_data;
   logic          o_ir_valid;
   logic [DW-1:0] o_ir_data;
   logic          i_ir_ready;
   logic [DW-1:0] o_pointer;
   logic          o_stopped;
`ifdef IR_JUMP_STATS_EN
   logic [15:0]   o_jump_taken_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   ir_pointer_unit #(.DATA_WIDTH(DW), .RESET_ADDR(16'h0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_ir_mode     (i_ir_mode),
      .i_jump_valid  (i_jump_valid),
      .i_jump_cmd    (i_jump_cmd),
      .i_jump_target (i_jump_target),
      .i_flags       (i_flags),
      .i_resume      (i_resume),
      .o_fetch_req   (o_fetch_req),
      .o_fetch_addr  (o_fetch_addr),
      .i_fetch_ack   (i_fetch_ack),
      .i_fetch_data  (i_fetch_data),
      .o_ir_valid    (o_ir_valid),
      .o_ir_data     (o_ir_data),
      .i_ir_ready    (i_ir_ready),
      .o_pointer     (o_pointer),
      .o_stopped     (o_stopped)
`ifdef IR_JUMP_STATS_EN
      ,
      .o_jump_taken_cnt (o_jump_taken_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cmd;
      logic [2:0]  flags;
      logic [15:0] target;
      logic [15:0] exp_ptr;   // pointer / next fetch address after jump+ready
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for a request, checks its address, acks one cycle later.
   task automatic fetch(input logic [15:0] data, input logic [15:0] exp_addr);
      int n = 0;
      while (!o_fetch_req && n < 20) begin
         step();
         n++;
      end
      check("fetch_req_seen", {31'd0, o_fetch_req}, 32'd1);
      check("fetch_addr", {16'd0, o_fetch_addr}, {16'd0, exp_addr});
      step();
      i_fetch_ack  = 1'b1;
      i_fetch_data = data;
      step();
      i_fetch_ack  = 1'b0;
      check("ir_valid_after_ack", {31'd0, o_ir_valid}, 32'd1);
      check("ir_data_after_ack", {16'd0, o_ir_data}, {16'd0, data});
   endtask

   task automatic clear_cmd();
      i_jump_valid  = 1'b0;
      i_jump_cmd    = CMD_NONE;
      i_flags       = 3'b000;
      i_jump_target = 16'h0000;
      i_ir_ready    = 1'b0;
      i_resume      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] prev_addr;
      int          req_seen;

      vecs[0]  = '{CMD_EQUAL,   3'b001, 16'h0040, 16'h0040};
      vecs[1]  = '{CMD_EQUAL,   3'b100, 16'h0080, 16'h0041};
      vecs[2]  = '{CMD_LARGER,  3'b100, 16'h0100, 16'h0100};
      vecs[3]  = '{CMD_LARGER,  3'b011, 16'h0200, 16'h0101};
      vecs[4]  = '{CMD_SMALLER, 3'b010, 16'h0300, 16'h0300};
      vecs[5]  = '{CMD_SMALLER, 3'b101, 16'h0400, 16'h0301};
      vecs[6]  = '{CMD_UNEQUAL, 3'b110, 16'h0500, 16'h0500};
      vecs[7]  = '{CMD_UNEQUAL, 3'b001, 16'h0600, 16'h0501};
      vecs[8]  = '{CMD_DIRECT,  3'b000, 16'h0700, 16'h0700};
      vecs[9]  = '{CMD_NONE,    3'b111, 16'h0800, 16'h0701};
      vecs[10] = '{CMD_DIRECT,  3'b000, 16'hFFFF, 16'hFFFF};

      rst          = 1'b1;
      i_ir_mode    = MODE_IDLE;
      i_fetch_ack  = 1'b0;
      i_fetch_data = 16'h0000;
      clear_cmd();
      step();
      step();
      check("rst_pointer",   {16'd0, o_pointer}, 32'h0);
      check("rst_fetch_req", {31'd0, o_fetch_req}, 32'd0);
      check("rst_ir_valid",  {31'd0, o_ir_valid}, 32'd0);
      check("rst_ir_data",   {16'd0, o_ir_data}, 32'h0);
      check("rst_stopped",   {31'd0, o_stopped}, 32'd0);

      // First fetch after reset, ack one cycle after the request.
      rst       = 1'b0;
      i_ir_mode = MODE_WORK;
      step();
      fetch(16'h1234, 16'h0000);
      check("first_pointer", {16'd0, o_pointer}, 32'h1);
      step(); step(); step();
      check("valid_held_no_ready", {31'd0, o_ir_valid}, 32'd1);
      check("no_req_while_held",   {31'd0, o_fetch_req}, 32'd0);
      i_ir_ready = 1'b1;
      step();
      i_ir_ready = 1'b0;
      check("valid_cleared_on_ready", {31'd0, o_ir_valid}, 32'd0);
      check("req_after_ready",        {31'd0, o_fetch_req}, 32'd1);
      check("addr_after_ready",       {16'd0, o_fetch_addr}, 32'h1);

      // Table: fetch, then jump command together with ready.
      prev_addr = 16'h0001;
      for (int i = 0; i < 11; i++) begin
         fetch(16'hA000 + 16'(i), prev_addr);
         i_jump_valid  = 1'b1;
         i_jump_cmd    = vecs[i].cmd;
         i_flags       = vecs[i].flags;
         i_jump_target = vecs[i].target;
         i_ir_ready    = 1'b1;
         step();
         clear_cmd();
         check($sformatf("vec%0d_req", i),  {31'd0, o_fetch_req}, 32'd1);
         check($sformatf("vec%0d_addr", i), {16'd0, o_fetch_addr}, {16'd0, vecs[i].exp_ptr});
         prev_addr = vecs[i].exp_ptr;
      end

      // Pointer wrap from all-ones.
      fetch(16'h7777, 16'hFFFF);
      check("wrap_pointer", {16'd0, o_pointer}, 32'h0);
      i_ir_ready = 1'b1;
      step();
      i_ir_ready = 1'b0;
      check("wrap_next_addr", {16'd0, o_fetch_addr}, 32'h0);

      // Jumps before ready: applied at once, last one wins.
      fetch(16'h1111, 16'h0000);
      i_jump_valid = 1'b1; i_jump_cmd = CMD_DIRECT; i_jump_target = 16'h0123;
      step();
      check("early_jump_pointer", {16'd0, o_pointer}, 32'h0123);
      check("early_jump_valid",   {31'd0, o_ir_valid}, 32'd1);
      i_jump_target = 16'h0456;
      step();
      clear_cmd();
      check("second_jump_pointer", {16'd0, o_pointer}, 32'h0456);
      i_ir_ready = 1'b1;
      step();
      i_ir_ready = 1'b0;
      check("last_jump_wins_addr", {16'd0, o_fetch_addr}, 32'h0456);

      // WAIT: no requests, jump ignored, resume at unchanged pointer.
      fetch(16'h2222, 16'h0456);
      i_jump_valid = 1'b1; i_jump_cmd = CMD_WAIT; i_ir_ready = 1'b1;
      step();
      clear_cmd();
      i_jump_valid = 1'b1; i_jump_cmd = CMD_DIRECT; i_jump_target = 16'h0999;
      req_seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (o_fetch_req) req_seen++;
         step();
      end
      clear_cmd();
      check("wait_no_requests", req_seen, 0);
      check("wait_ir_valid",    {31'd0, o_ir_valid}, 32'd0);
      check("wait_pointer",     {16'd0, o_pointer}, 32'h0457);
      i_resume = 1'b1;
      step();
      i_resume = 1'b0;
      check("resume_req",  {31'd0, o_fetch_req}, 32'd1);
      check("resume_addr", {16'd0, o_fetch_addr}, 32'h0457);

      // STOP, then RST mode and WORK again.
      fetch(16'h3333, 16'h0457);
      i_jump_valid = 1'b1; i_jump_cmd = CMD_STOP; i_ir_ready = 1'b1;
      step();
      clear_cmd();
      check("stop_stopped", {31'd0, o_stopped}, 32'd1);
      req_seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (o_fetch_req) req_seen++;
         step();
      end
      check("stop_no_requests", req_seen, 0);
      check("stop_pointer", {16'd0, o_pointer}, 32'h0458);
`ifdef IR_JUMP_STATS_EN
      check("jump_cnt", {16'd0, o_jump_taken_cnt}, 32'd8);
`endif
      i_ir_mode = MODE_RST;
      step();
      check("stop_cleared", {31'd0, o_stopped}, 32'd0);
      check("rst_mode_pointer", {16'd0, o_pointer}, 32'h0);
`ifdef IR_JUMP_STATS_EN
      check("jump_cnt_cleared", {16'd0, o_jump_taken_cnt}, 32'd0);
`endif
      i_ir_mode = MODE_WORK;
      step();
      check("restart_req",  {31'd0, o_fetch_req}, 32'd1);
      check("restart_addr", {16'd0, o_fetch_addr}, 32'h0);

      // RST mode while a request is outstanding; late ack dropped.
      fetch(16'h4444, 16'h0000);
      i_ir_ready = 1'b1;
      step();
      i_ir_ready = 1'b0;
      check("pre_rst_req", {31'd0, o_fetch_req}, 32'd1);
      i_ir_mode = MODE_RST;
      step();
      check("rst_mid_req_dropped", {31'd0, o_fetch_req}, 32'd0);
      i_fetch_ack = 1'b1; i_fetch_data = 16'hBEEF;
      step();
      i_fetch_ack = 1'b0;
      check("late_ack_valid",   {31'd0, o_ir_valid}, 32'd0);
      check("late_ack_data",    {16'd0, o_ir_data}, 32'h0);
      check("late_ack_pointer", {16'd0, o_pointer}, 32'h0);
      i_ir_mode = MODE_WORK;
      step();
      check("after_rst_addr", {16'd0, o_fetch_addr}, 32'h0);

      // IDLE: request dropped, ack and ready ignored, state frozen.
      i_ir_mode = MODE_IDLE;
      step();
      check("idle_req_low", {31'd0, o_fetch_req}, 32'd0);
      i_fetch_ack = 1'b1; i_fetch_data = 16'hDEAD;
      step();
      i_fetch_ack = 1'b0;
      check("idle_ack_ignored", {31'd0, o_ir_valid}, 32'd0);
      check("idle_pointer",     {16'd0, o_pointer}, 32'h0);
      i_ir_mode = MODE_WORK;
      step();
      fetch(16'h5A5A, 16'h0000);
      i_ir_mode  = MODE_RSVD;
      i_ir_ready = 1'b1;
      step();
      i_ir_ready = 1'b0;
      check("idle_ready_ignored", {31'd0, o_ir_valid}, 32'd1);
      check("idle_data_kept",     {16'd0, o_ir_data}, 32'h5A5A);
      i_ir_mode  = MODE_WORK;
      i_ir_ready = 1'b1;
      step();
      i_ir_ready = 1'b0;
      check("idle_resume_req",  {31'd0, o_fetch_req}, 32'd1);
      check("idle_resume_addr", {16'd0, o_fetch_addr}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
